// File: rtl/hazard_track_unit_if.sv
// ID-stage request fields and hazard/tracking results exchanged with hazard_track_unit.
// The unit drives the slave side; the pipeline control drives the master side.
interface hazard_track_unit_if #(
  parameter int unsigned CNT_W = 32
);
  logic [4:0]       RS1Addr_ID;
  logic [4:0]       RS2Addr_ID;
  logic             Use1_ID;
  logic             Use2_ID;
  logic [4:0]       RDAddr_ID;
  logic             RegWrite_ID;
  logic             MemRead_ID;
  logic             Branch_ID;
  logic             BranchTaken_ID;
  logic [4:0]       RS1Addr_EX;
  logic [4:0]       RS2Addr_EX;
  logic [4:0]       RDAddr_MEM;
  logic             RegWrite_MEM;
  logic [4:0]       RDAddr_WB;
  logic             RegWrite_WB;
  logic             Stall_o;
  logic             Flush_o;
  logic [CNT_W-1:0] StallCnt_o;
  logic [CNT_W-1:0] FlushCnt_o;

  modport master (
    output RS1Addr_ID, RS2Addr_ID, Use1_ID, Use2_ID, RDAddr_ID,
           RegWrite_ID, MemRead_ID, Branch_ID, BranchTaken_ID,
    input  RS1Addr_EX, RS2Addr_EX, RDAddr_MEM, RegWrite_MEM, RDAddr_WB,
           RegWrite_WB, Stall_o, Flush_o, StallCnt_o, FlushCnt_o
  );

  modport slave (
    input  RS1Addr_ID, RS2Addr_ID, Use1_ID, Use2_ID, RDAddr_ID,
           RegWrite_ID, MemRead_ID, Branch_ID, BranchTaken_ID,
    output RS1Addr_EX, RS2Addr_EX, RDAddr_MEM, RegWrite_MEM, RDAddr_WB,
           RegWrite_WB, Stall_o, Flush_o, StallCnt_o, FlushCnt_o
  );
endinterface

// File: rtl/hazard_track_unit.sv
// ID-stage hazard unit: tracks rd/rs through EX/MEM/WB, stalls on load-use and unready branch operands.
// Define HAZARD_PERF_CNT_EN to add saturating stall/flush counters.
module hazard_track_unit #(
  parameter int unsigned CNT_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  hazard_track_unit_if.slave    bus
);

  logic [4:0] rd_ex, rs1_ex, rs2_ex, rd_mem, rd_wb;
  logic       we_ex, ld_ex, we_mem, ld_mem, we_wb;
  logic       m1_ex, m2_ex, m1_mem, m2_mem;
  logic       h1, h2, h3, stall, flush;

  function automatic logic match(input logic [4:0] rs, input logic used,
                                 input logic [4:0] rd, input logic we);
    return used && we && (rd != 5'd0) && (rd == rs);
  endfunction

  always_comb begin
    m1_ex  = match(bus.RS1Addr_ID, bus.Use1_ID, rd_ex,  we_ex);
    m2_ex  = match(bus.RS2Addr_ID, bus.Use2_ID, rd_ex,  we_ex);
    m1_mem = match(bus.RS1Addr_ID, bus.Use1_ID, rd_mem, we_mem);
    m2_mem = match(bus.RS2Addr_ID, bus.Use2_ID, rd_mem, we_mem);
    h1     = ld_ex && (m1_ex || m2_ex);
    h2     = bus.Branch_ID && !ld_ex && (m1_ex || m2_ex);
    h3     = bus.Branch_ID && ld_mem && (m1_mem || m2_mem);
    stall  = h1 || h2 || h3;
    // Gated by reset so a branch presented during reset cannot raise a flush.
    flush  = rst_i && bus.Branch_ID && bus.BranchTaken_ID && !stall;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_ex  <= '0;
      rs1_ex <= '0;
      rs2_ex <= '0;
      we_ex  <= 1'b0;
      ld_ex  <= 1'b0;
      rd_mem <= '0;
      we_mem <= 1'b0;
      ld_mem <= 1'b0;
      rd_wb  <= '0;
      we_wb  <= 1'b0;
    end else begin
      rd_mem <= rd_ex;
      we_mem <= we_ex;
      ld_mem <= ld_ex;
      rd_wb  <= rd_mem;
      we_wb  <= we_mem;
      if (stall) begin
        rd_ex  <= '0;
        rs1_ex <= '0;
        rs2_ex <= '0;
        we_ex  <= 1'b0;
        ld_ex  <= 1'b0;
      end else begin
        rd_ex  <= bus.RDAddr_ID;
        rs1_ex <= bus.Use1_ID ? bus.RS1Addr_ID : 5'd0;
        rs2_ex <= bus.Use2_ID ? bus.RS2Addr_ID : 5'd0;
        we_ex  <= bus.RegWrite_ID;
        ld_ex  <= bus.MemRead_ID;
      end
    end
  end

  assign bus.RS1Addr_EX   = rs1_ex;
  assign bus.RS2Addr_EX   = rs2_ex;
  assign bus.RDAddr_MEM   = rd_mem;
  assign bus.RegWrite_MEM = we_mem;
  assign bus.RDAddr_WB    = rd_wb;
  assign bus.RegWrite_WB  = we_wb;
  assign bus.Stall_o      = stall;
  assign bus.Flush_o      = flush;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign bus.StallCnt_o = stall_cnt;
  assign bus.FlushCnt_o = flush_cnt;
`else
  assign bus.StallCnt_o = '0;
  assign bus.FlushCnt_o = '0;
`endif

endmodule
